// File: rtl/xosera_pkg.sv
// Shared constants and state encoding for the m68k-style bus interface.
package xosera_pkg;

  localparam logic cs_ENABLED = 1'b0;  // chip select is active low
  localparam logic RnW_READ   = 1'b1;  // rd_nwr high means read

  typedef enum logic [1:0] {
    StWaitIdle,
    StIdle,
    StReadWait,
    StActive
  } bus_state_e;

endpackage

// File: rtl/bus_sync.sv
// Multi-flop synchronizer for a single asynchronous level, resetting to 1 (deasserted).
module bus_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset_n_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/bus_intf.sv
// Asynchronous m68k-style bus to register-file bridge: one read or write strobe per
// chip-select assertion, with byte assembly for writes and byte selection for reads.
module bus_intf
  import xosera_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n_i,
  input  logic        bus_cs_n_i,
  input  logic        bus_rd_nwr_i,
  input  logic        bus_bytesel_i,
  input  logic [3:0]  bus_reg_num_i,
  input  logic [7:0]  bus_data_i,
  output logic [7:0]  bus_data_o,
  input  logic [15:0] reg_read_data_i,
  output logic        reg_write_strobe_o,
  output logic        reg_read_strobe_o,
  output logic [3:0]  reg_num_o,
  output logic        reg_bytesel_o,
  output logic [15:0] reg_data_o
);

  localparam logic [2:0] SettleCnt = 3'(SYNC_STAGES);

  logic        cs_n_sync;
  bus_state_e  state_q;
  logic [2:0]  settle_q;
  logic        rd_phase_q;
  logic [7:0]  hi_byte_q;
  logic [7:0]  bus_data_q;
  logic        wr_stb_q;
  logic        rd_stb_q;
  logic [3:0]  reg_num_q;
  logic        bytesel_q;
  logic [15:0] reg_data_q;

  bus_sync #(
    .STAGES (SYNC_STAGES)
  ) u_cs_sync (
    .clk       (clk),
    .reset_n_i (reset_n_i),
    .d_i       (bus_cs_n_i),
    .q_o       (cs_n_sync)
  );

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= StWaitIdle;
      settle_q   <= '0;
      rd_phase_q <= 1'b0;
      hi_byte_q  <= '0;
      bus_data_q <= '0;
      wr_stb_q   <= 1'b0;
      rd_stb_q   <= 1'b0;
      reg_num_q  <= '0;
      bytesel_q  <= 1'b0;
      reg_data_q <= '0;
    end else begin
      wr_stb_q <= 1'b0;
      rd_stb_q <= 1'b0;
      unique case (state_q)
        StWaitIdle: begin
          // The synchronizer output is only trusted once a full chain of real samples
          // has shifted through; a select already low at reset release is ignored.
          if (settle_q != SettleCnt) begin
            settle_q <= settle_q + 3'd1;
          end else if (cs_n_sync != cs_ENABLED) begin
            state_q <= StIdle;
          end
        end
        StIdle: begin
          if (cs_n_sync == cs_ENABLED) begin
            reg_num_q  <= bus_reg_num_i;
            bytesel_q  <= bus_bytesel_i;
            rd_phase_q <= 1'b0;
            if (bus_rd_nwr_i == RnW_READ) begin
              rd_stb_q <= 1'b1;
              state_q  <= StReadWait;
            end else begin
              wr_stb_q <= 1'b1;
              state_q  <= StActive;
              if (!bus_bytesel_i) begin
                hi_byte_q  <= bus_data_i;
                reg_data_q <= {bus_data_i, bus_data_i};
              end else begin
                reg_data_q <= {hi_byte_q, bus_data_i};
              end
            end
          end
        end
        StReadWait: begin
          // Register file answers one cycle after the strobe; latch on the second cycle.
          if (!rd_phase_q) begin
            rd_phase_q <= 1'b1;
          end else begin
            bus_data_q <= bytesel_q ? reg_read_data_i[7:0] : reg_read_data_i[15:8];
            state_q    <= (cs_n_sync == cs_ENABLED) ? StActive : StIdle;
          end
        end
        StActive: begin
          if (cs_n_sync != cs_ENABLED) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StWaitIdle;
      endcase
    end
  end

  assign bus_data_o         = bus_data_q;
  assign reg_write_strobe_o = wr_stb_q;
  assign reg_read_strobe_o  = rd_stb_q;
  assign reg_num_o          = reg_num_q;
  assign reg_bytesel_o      = bytesel_q;
  assign reg_data_o         = reg_data_q;

endmodule

// File: doc/bus_intf.md
BUS_INTF -- requirements
Module: bus_intf

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of flip-flops synchronizing bus_cs_n_i into clk (range 2..4).
REQ-002 clk  input  1  video pixel clock, sole clock of the block.
REQ-003 reset_n_i  input  1  asynchronous, active-low reset.
REQ-004 bus_cs_n_i  input  1  async m68k chip select, active LOW (cs_ENABLED).
REQ-005 bus_rd_nwr_i  input  1  async read HIGH (RnW_READ) / write LOW.
REQ-006 bus_bytesel_i  input  1  async byte select: even (high byte) LOW, odd (low byte) HIGH.
REQ-007 bus_reg_num_i  input  4  async 16-bit register index.
REQ-008 bus_data_i  input  8  async write data from tri-state pad.
REQ-009 bus_data_o  output  8  read data to tri-state pad.
REQ-010 reg_read_data_i  input  16  register-file read data; valid 1 cycle after reg_read_strobe_o.
REQ-011 reg_write_strobe_o  output  1  one-cycle register write pulse.
REQ-012 reg_read_strobe_o  output  1  one-cycle register read pulse.
REQ-013 reg_num_o  output  4  captured register index.
REQ-014 reg_bytesel_o  output  1  captured byte select.
REQ-015 reg_data_o  output  16  assembled write word {hi_byte, lo_byte}.

Function
REQ-016 bus_cs_n_i SHALL pass through a SYNC_STAGES flip-flop synchronizer; all other bus inputs SHALL be sampled unsynchronized, only in the capture cycle.
REQ-017 State machine SHALL have states WAIT_IDLE, IDLE, READ_WAIT, ACTIVE.
REQ-018 WAIT_IDLE: SHALL move to IDLE only when synced cs_n is high; no access starts from WAIT_IDLE.
REQ-019 IDLE: on synced cs_n low (capture cycle C), SHALL register reg_num, bytesel, rd_nwr, data and go to READ_WAIT if read, else ACTIVE.
REQ-020 Write, even byte: SHALL store data into hi_byte register, pulse reg_write_strobe_o at C+1 with reg_bytesel_o=0, reg_data_o={data, data}.
REQ-021 Write, odd byte: SHALL pulse reg_write_strobe_o at C+1 with reg_bytesel_o=1, reg_data_o={hi_byte, data}; hi_byte unchanged.
REQ-022 Read: SHALL pulse reg_read_strobe_o at C+1; at C+2 latch reg_read_data_i[15:8] (bytesel 0) or [7:0] (bytesel 1) into bus_data_o, valid from C+3; then go to ACTIVE.
REQ-023 bus_data_o SHALL hold its value until the next read latch.
REQ-024 ACTIVE: SHALL return to IDLE when synced cs_n is high; exactly one strobe per cs_n low period.
REQ-025 cs_n deassert during READ_WAIT SHALL still complete the latch, then go to IDLE without waiting in ACTIVE.
REQ-026 Strobes SHALL never both be high; each is exactly one cycle wide.
REQ-027 Back-to-back accesses with cs_n high for at least SYNC_STAGES+1 cycles between them SHALL each produce one strobe.

Reset
REQ-028 Asserting reset_n_i SHALL immediately clear all outputs to 0, hi_byte to 0, synchronizer flops to 1 (deasserted), state to WAIT_IDLE.
REQ-029 Reset mid-access SHALL discard the access; no strobe SHALL be issued for a cs_n period already low at reset release.

Structure
REQ-030 cs_ENABLED, RnW_READ constants and the state enum SHALL live in shared package xosera_pkg.
REQ-031 Synchronizer SHALL be sub-module bus_sync (parameter STAGES, reset value 1).

Verification
REQ-032 Write even reg 3 data 0xA5, then odd reg 3 data 0x5A -> two write strobes, second has reg_num_o=3, reg_data_o=0xA55A.
REQ-033 Read odd reg 7, reg_read_data_i=0x1234 -> one read strobe at C+1, bus_data_o=0x34 by C+3 and held after cs_n rises.
REQ-034 cs_n held low 50 cycles -> exactly one strobe.
REQ-035 Release reset while cs_n low -> no strobe until cs_n goes high then low again.
REQ-036 Assert reset_n_i during READ_WAIT -> outputs 0 immediately, no read latch.
REQ-037 cs_n low 1 cycle (shorter than sync window) vs. cs_n low SYNC_STAGES cycles -> document and check one strobe or none, never two.
